// File: rtl/inertial_filter_ctrl.sv
// inertial_filter_ctrl: per-channel inertial-delay glitch filter with a runtime threshold.
// Define GLITCH_CNT_EN to add glitch_clr/glitch_cnt, a saturating count of rejected pulses.
module inertial_filter_ctrl #(
   parameter int WIDTH     = 4,
   parameter int CNT_W     = 8,
   parameter int DEF_THR   = 3,
   parameter bit RESET_VAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] thr_in,
   output logic             cfg_ready,
   output logic [WIDTH-1:0] dout,
   output logic [WIDTH-1:0] edge_o
`ifdef GLITCH_CNT_EN
   ,
   input  logic             glitch_clr,
   output logic [15:0]      glitch_cnt
`endif
);

   typedef enum logic {ST_STABLE = 1'b0, ST_QUAL = 1'b1} state_t;

   state_t           state_p0 [WIDTH];
   state_t           state_nx [WIDTH];
   logic [CNT_W-1:0] cnt_p0   [WIDTH];
   logic [CNT_W-1:0] cnt_nx   [WIDTH];
   logic [CNT_W-1:0] thr_p0;
   logic [WIDTH-1:0] dout_p0;
   logic [WIDTH-1:0] edge_p0;
   logic [WIDTH-1:0] flip;
   logic [WIDTH-1:0] glitch;
   logic [WIDTH-1:0] is_stable;
   logic             accept;

   function automatic logic [CNT_W-1:0] norm_thr(input logic [CNT_W-1:0] t);
      return (t == '0) ? CNT_W'(1) : t;
   endfunction

   // ">=" rather than "==" so a channel that entered QUAL on the edge where a
   // smaller threshold was loaded still resolves instead of counting on.
   function automatic logic qual_done(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] t);
      logic [CNT_W:0] nxt;
      nxt = {1'b0, c} + (CNT_W+1)'(1);
      return nxt >= {1'b0, t};
   endfunction

   // ---- stage p0: channel state, counters, outputs, threshold ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            state_p0[i] <= ST_STABLE;
            cnt_p0[i]   <= '0;
         end
         dout_p0 <= {WIDTH{RESET_VAL}};
         edge_p0 <= '0;
         thr_p0  <= CNT_W'(DEF_THR);
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            state_p0[i] <= state_nx[i];
            cnt_p0[i]   <= cnt_nx[i];
         end
         dout_p0 <= dout_p0 ^ flip;
         edge_p0 <= flip;
         if (accept) thr_p0 <= norm_thr(thr_in);
      end
   end

   always_comb begin
      flip   = '0;
      glitch = '0;
      for (int i = 0; i < WIDTH; i++) begin
         state_nx[i] = state_p0[i];
         cnt_nx[i]   = cnt_p0[i];
         case (state_p0[i])
            ST_STABLE: begin
               if (din[i] != dout_p0[i]) begin
                  if (thr_p0 == CNT_W'(1)) begin
                     flip[i] = 1'b1;
                  end else begin
                     cnt_nx[i]   = CNT_W'(1);
                     state_nx[i] = ST_QUAL;
                  end
               end
            end
            ST_QUAL: begin
               if (din[i] == dout_p0[i]) begin
                  glitch[i]   = 1'b1;
                  cnt_nx[i]   = '0;
                  state_nx[i] = ST_STABLE;
               end else if (qual_done(cnt_p0[i], thr_p0)) begin
                  flip[i]     = 1'b1;
                  cnt_nx[i]   = '0;
                  state_nx[i] = ST_STABLE;
               end else begin
                  cnt_nx[i] = cnt_p0[i] + CNT_W'(1);
               end
            end
            default: begin
               state_nx[i] = ST_STABLE;
               cnt_nx[i]   = '0;
            end
         endcase
      end
   end

   // Threshold may only change while no channel is mid-qualification.
   always_comb begin
      is_stable = '0;
      for (int i = 0; i < WIDTH; i++) begin
         is_stable[i] = (state_p0[i] == ST_STABLE);
      end
      cfg_ready = &is_stable;
      accept    = cfg_valid & cfg_ready;
   end

   assign dout   = dout_p0;
   assign edge_o = edge_p0;

`ifdef GLITCH_CNT_EN
   localparam int POP_W = $clog2(WIDTH + 1);

   function automatic logic [POP_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + POP_W'(v[i]);
      return n;
   endfunction

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [POP_W-1:0] b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [15:0] glitch_cnt_p0;

   // ---- stage p0: rejected-pulse counter ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         glitch_cnt_p0 <= '0;
      end else if (glitch_clr) begin
         glitch_cnt_p0 <= '0;
      end else begin
         glitch_cnt_p0 <= sat_add16(glitch_cnt_p0, popcount(glitch));
      end
   end

   assign glitch_cnt = glitch_cnt_p0;
`else
   logic unused_glitch;
   assign unused_glitch = ^glitch;
`endif

endmodule
